fifo_reader: RTL

//  Read-side master for the fifo block: pops words via fifo_rd_en, absorbs the 1-cycle read latency
//  (fifo data_out updates on the edge that samples rd_en), presents the words as a valid/ready stream.

---
 rtl/fifo_reader_pkg.sv | 21 ++
 rtl/fifo_reader_buf.sv | 68 ++++++
 rtl/fifo_reader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the fifo read-side master: FSM encoding,
// local buffer geometry and the 3-entry pointer increment helper.
// No ports; imported by fifo_reader and fifo_reader_buf.
package fifo_reader_pkg;

  // RUN delivers words downstream; FLUSH drains the fifo and discards everything.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Three entries cover the 1-cycle fifo read latency plus one beat in
  // flight, which keeps one beat per cycle with a registered rd_en credit.
  localparam int BUF_DEPTH = 3;

  // Pointers wrap 2 -> 0 because the depth is not a power of two.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// 3-entry circular skid buffer between fifo read data and the output stream.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; clear wins over push/pop.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           drop all entries (pointers and occupancy to 0)
//   push, push_data write push_data at the write pointer
//   pop             retire the head entry
//   head            entry at the read pointer
//   occ             number of buffered entries (0..3)
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Read-side master for a 1-cycle-latency fifo; presents the words as a valid/ready stream.
// Latency: rd_en in cycle N gives m_valid in cycle N+2; one beat per cycle in steady state.
// Backpressure: rd_en issued only on buffer credit (occ + inflight < 3); no m_ready->rd_en comb path.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   fifo_data, fifo_empty  fifo read data (valid the cycle after rd_en) and empty flag
//   fifo_rd_en             fifo read enable
//   m_data, m_valid, m_ready  output stream
//   flush                  1-cycle request: discard local buffer and drain the fifo
//   flush_busy, flush_done flush in progress / 1-cycle pulse when it completes
//   beat_cnt               delivered beats, wraps
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  state_t     state;
  state_t     state_nxt;
  logic       inflight;
  logic [1:0] occ;
  logic       credit_ok;
  logic       beat;
  logic       flush_go;
  logic       push;

  // Words already buffered plus the one returning from the fifo must fit.
  assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < 3'(BUF_DEPTH);
  assign beat      = m_valid && m_ready;
  assign flush_go  = (state == ST_RUN) && flush;
  // During FLUSH the returning words are simply not captured.
  assign push      = inflight && (state == ST_RUN);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Wait for the last issued read to return before declaring drained.
        if (fifo_empty && !inflight) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    fifo_rd_en = 1'b0;
    flush_busy = 1'b0;
    case (state)
      ST_RUN: begin
        fifo_rd_en = !fifo_empty && credit_ok;
      end
      ST_FLUSH: begin
        fifo_rd_en = !fifo_empty;
        flush_busy = 1'b1;
      end
      default: begin
        fifo_rd_en = 1'b0;
        flush_busy = 1'b0;
      end
    endcase
    // Reset must block reads immediately, independent of the async-cleared state.
    if (!rst) begin
      fifo_rd_en = 1'b0;
    end
    // occ is held at 0 throughout FLUSH, so no state qualifier is needed.
    m_valid = (occ != 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight   <= 1'b0;
      flush_done <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      inflight   <= fifo_rd_en;
      flush_done <= (state == ST_FLUSH) && (state_nxt == ST_RUN);
      if (beat) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  fifo_reader_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_go),
    .push      (push),
    .push_data (fifo_data),
    .pop       (beat),
    .head      (m_data),
    .occ       (occ)
  );

endmodule
